// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write/read controllers: default widths and
// the two-state write FSM encoding.
package fifo_wr_arbiter_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefAddrW = 3;
  localparam int unsigned DefPtrW  = DefAddrW + 1;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } wr_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_arb2.sv
// Two-way round-robin pick. A lone requester wins outright; when both request,
// the one that did not win last time is chosen.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic valid,
  output logic winner
);

  // Combinational pick: winner is the requester index, meaningful only when valid.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last_winner;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write side of an async FIFO shared by two requesters. Each accepted item
// takes two cycles: capture in IDLE, RAM write plus grant pulse in WRITE.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt1,
  input  logic [ADDR_W:0]   rptr_sync,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [ADDR_W:0]   wptr,
  output logic              full
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  wr_state_e         state_q;
  logic              last_winner_q;
  logic [PTR_W-1:0]  wptr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wen_q;
  logic              gnt0_q;
  logic              gnt1_q;

  logic arb_valid;
  logic arb_winner;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_winner (last_winner_q),
    .valid       (arb_valid),
    .winner      (arb_winner)
  );

  // Full when pointers differ only in the wrap bit.
  always_comb begin
    full = (wptr_q[ADDR_W] != rptr_sync[ADDR_W]) &&
           (wptr_q[ADDR_W-1:0] == rptr_sync[ADDR_W-1:0]);
  end

  // Write FSM with registered RAM-side outputs; reset aborts any write in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      last_winner_q <= 1'b1;
      wptr_q        <= '0;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wen_q         <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!full && arb_valid) begin
            state_q       <= StWrite;
            last_winner_q <= arb_winner;
            wdata_q       <= arb_winner ? data1 : data0;
            waddr_q       <= wptr_q[ADDR_W-1:0];
            wen_q         <= 1'b1;
            gnt0_q        <= ~arb_winner;
            gnt1_q        <= arb_winner;
          end
        end
        StWrite: begin
          // Requests are not sampled here; the pointer advances as the write retires.
          state_q <= StIdle;
          wptr_q  <= wptr_q + PTR_W'(1);
          wen_q   <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          wen_q   <= 1'b0;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  // Drive ports straight from registers.
  always_comb begin
    wen   = wen_q;
    gnt0  = gnt0_q;
    gnt1  = gnt1_q;
    waddr = waddr_q;
    wdata = wdata_q;
    wptr  = wptr_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expectations.
module tb_fifo_wr_arbiter;

  logic       clk;
  logic       rstn;
  logic       req0;
  logic [7:0] data0;
  logic       gnt0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt1;
  logic [3:0] rptr_sync;
  logic       wen;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [3:0] wptr;
  logic       full;

  int passed;
  int total;

  fifo_wr_arbiter #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req0      (req0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .data1     (data1),
    .gnt1      (gnt1),
    .rptr_sync (rptr_sync),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .wptr      (wptr),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_wptr;
    logic       exp_win;
    logic [7:0] exp_data;

    passed    = 0;
    total     = 0;
    rstn      = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    data0     = 8'h00;
    data1     = 8'h00;
    rptr_sync = 4'h0;

    // Reset state
    #7;
    chk("rst_wen", wen, 0);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wptr", wptr, 0);
    chk("rst_full", full, 0);

    // Single write from requester 0
    #5;
    rstn  = 1'b1;
    req0  = 1'b1;
    data0 = 8'hA5;
    tick();
    chk("w1_wen", wen, 1);
    chk("w1_waddr", waddr, 0);
    chk("w1_wdata", wdata, 8'hA5);
    chk("w1_gnt0", gnt0, 1);
    chk("w1_gnt1", gnt1, 0);
    req0 = 1'b0;
    tick();
    chk("w1_wptr", wptr, 1);
    chk("w1_idle_wen", wen, 0);
    chk("w1_idle_gnt0", gnt0, 0);
    chk("w1_hold_wdata", wdata, 8'hA5);
    tick();
    chk("w1_noreq_wen", wen, 0);

    // Both requesting from reset: grants alternate 0,1,0,1
    rstn = 1'b0;
    #2;
    rstn  = 1'b1;
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h30;
    data1 = 8'h40;
    for (int i = 0; i < 4; i++) begin
      exp_win  = 1'(i % 2);
      exp_data = exp_win ? (8'h40 + 8'(i)) : (8'h30 + 8'(i));
      tick();
      chk($sformatf("alt%0d_wen", i), wen, 1);
      chk($sformatf("alt%0d_gnt0", i), gnt0, 32'(!exp_win));
      chk($sformatf("alt%0d_gnt1", i), gnt1, 32'(exp_win));
      chk($sformatf("alt%0d_waddr", i), waddr, 32'(i));
      chk($sformatf("alt%0d_wdata", i), wdata, 32'(exp_data));
      data0 = 8'h30 + 8'(i + 1);
      data1 = 8'h40 + 8'(i + 1);
      tick();
      chk($sformatf("alt%0d_idle_wen", i), wen, 0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("alt_wptr", wptr, 4);

    // Fill to full with rptr_sync held at 0
    rstn = 1'b0;
    #2;
    rstn      = 1'b1;
    rptr_sync = 4'h0;
    req0      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data0 = 8'h80 + 8'(i);
      tick();
      chk($sformatf("fill%0d_waddr", i), waddr, 32'(i));
      tick();
    end
    chk("fill_wptr", wptr, 4'b1000);
    chk("fill_full", full, 1);
    data0 = 8'hC3;
    tick();
    chk("full_wait_wen", wen, 0);
    chk("full_wait_gnt0", gnt0, 0);
    tick();
    chk("full_wait_wen2", wen, 0);
    chk("full_wait_wptr", wptr, 4'b1000);
    rptr_sync = 4'b0001;
    #1;
    chk("unfull", full, 0);
    tick();
    chk("ninth_wen", wen, 1);
    chk("ninth_waddr", waddr, 0);
    chk("ninth_wdata", wdata, 8'hC3);
    chk("ninth_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick();
    chk("ninth_wptr", wptr, 4'b1001);

    // Sixteen writes from requester 1 with rptr_sync tracking; wraps 1111 -> 0000
    exp_wptr = 4'b1001;
    req1     = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rptr_sync = exp_wptr;
      data1     = 8'h50 + 8'(i);
      #1;
      chk($sformatf("wrap%0d_full_pre", i), full, 0);
      tick();
      chk($sformatf("wrap%0d_wen", i), wen, 1);
      chk($sformatf("wrap%0d_gnt1", i), gnt1, 1);
      chk($sformatf("wrap%0d_waddr", i), waddr, 32'(exp_wptr[2:0]));
      tick();
      exp_wptr = exp_wptr + 4'd1;
      chk($sformatf("wrap%0d_wptr", i), wptr, 32'(exp_wptr));
      chk($sformatf("wrap%0d_full", i), full, 0);
    end

    // Reset in the middle of a WRITE cycle
    rptr_sync = exp_wptr;
    data1     = 8'h77;
    tick();
    chk("abort_wen_pre", wen, 1);
    chk("abort_gnt1_pre", gnt1, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_wen", wen, 0);
    chk("abort_gnt1", gnt1, 0);
    chk("abort_wptr", wptr, 0);
    rptr_sync = 4'h0;
    tick();
    chk("abort_hold_wen", wen, 0);
    chk("abort_hold_gnt0", gnt0, 0);
    chk("abort_hold_gnt1", gnt1, 0);
    req0  = 1'b1;
    req1  = 1'b1;
    data0 = 8'h5A;
    data1 = 8'h6B;
    rstn  = 1'b1;
    tick();
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);
    chk("post_rst_wdata", wdata, 8'h5A);
    chk("post_rst_waddr", waddr, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("post_rst_wptr", wptr, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
